// File: rtl/can_bit_sequencer_if.sv
// Bit-stream signals between the sample-point logic / frame decoder and the bit sequencer.
// The master modport is the side that drives samples and decoder indications.
interface can_bit_sequencer_if;
   logic       SP;
   logic       RX;
   logic       STF_EN;
   logic       EOF_DONE;
   logic       FORM_ERR;
   logic       BIT_VALID;
   logic       BIT_OUT;
   logic       FR_RESET;
   logic       STUFF_ERR;
   logic       BUS_IDLE;
   logic       ERR_ACTIVE;
   logic [2:0] STATE;

   modport master (
      output SP, RX, STF_EN, EOF_DONE, FORM_ERR,
      input  BIT_VALID, BIT_OUT, FR_RESET, STUFF_ERR, BUS_IDLE, ERR_ACTIVE, STATE
   );

   modport slave (
      input  SP, RX, STF_EN, EOF_DONE, FORM_ERR,
      output BIT_VALID, BIT_OUT, FR_RESET, STUFF_ERR, BUS_IDLE, ERR_ACTIVE, STATE
   );
endinterface

// File: rtl/can_bit_sequencer.sv
// CAN bit-level controller: bus integration, SOF detection, destuffing, stuff-error detection
// and error flag / delimiter / intermission sequencing back to bus idle.
module can_bit_sequencer #(
   parameter int unsigned IDLE_BITS = 11,
   parameter int unsigned STUFF_LEN = 5
) (
   input logic                  clk,
   input logic                  reset,
   can_bit_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {
      S_INTEG     = 3'd0,
      S_IDLE      = 3'd1,
      S_FRAME     = 3'd2,
      S_INTERM    = 3'd3,
      S_ERR_FLAG  = 3'd4,
      S_ERR_DELIM = 3'd5
   } state_t;

   localparam logic [3:0] IDLE_CNT   = 4'(IDLE_BITS);
   localparam logic [3:0] STUFF_CNT  = 4'(STUFF_LEN);
   localparam logic [3:0] INTERM_CNT = 4'd3;
   localparam logic [3:0] FLAG_CNT   = 4'd6;
   localparam logic [3:0] DELIM_CNT  = 4'd8;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d, run_q, run_d, cnt_inc;
   logic       last_q, last_d;
   logic       bit_valid_q, bit_valid_d, bit_out_q, bit_out_d;
   logic       fr_reset_q, fr_reset_d, stuff_err_q, stuff_err_d;
   logic       bus_idle_q, bus_idle_d, err_active_q, err_active_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_INTEG;
         cnt_q        <= '0;
         run_q        <= '0;
         last_q       <= 1'b1;
         bit_valid_q  <= 1'b0;
         bit_out_q    <= 1'b1;
         fr_reset_q   <= 1'b0;
         stuff_err_q  <= 1'b0;
         bus_idle_q   <= 1'b0;
         err_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         run_q        <= run_d;
         last_q       <= last_d;
         bit_valid_q  <= bit_valid_d;
         bit_out_q    <= bit_out_d;
         fr_reset_q   <= fr_reset_d;
         stuff_err_q  <= stuff_err_d;
         bus_idle_q   <= bus_idle_d;
         err_active_q <= err_active_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_d       = run_q;
      last_d      = last_q;
      bit_valid_d = 1'b0;
      bit_out_d   = bit_out_q;
      fr_reset_d  = 1'b0;
      stuff_err_d = 1'b0;
      cnt_inc     = cnt_q + 4'd1;

      case (state_q)
         S_INTEG: begin
            if (bus.SP) begin
               if (!bus.RX) begin
                  cnt_d = '0;
               end else if (cnt_inc >= IDLE_CNT) begin
                  state_d    = S_IDLE;
                  cnt_d      = '0;
                  fr_reset_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_IDLE: begin
            if (bus.SP && !bus.RX) begin
               state_d     = S_FRAME;
               bit_valid_d = 1'b1;
               bit_out_d   = 1'b0;
               last_d      = 1'b0;
               run_d       = 4'd1;
            end
         end
         S_FRAME: begin
            if (bus.FORM_ERR) begin
               state_d    = S_ERR_FLAG;
               cnt_d      = '0;
               fr_reset_d = 1'b1;
            end else if (bus.EOF_DONE) begin
               // A coincident sample is already the first intermission bit.
               state_d = S_INTERM;
               cnt_d   = '0;
               if (bus.SP) begin
                  if (!bus.RX) begin
                     state_d    = S_ERR_FLAG;
                     fr_reset_d = 1'b1;
                  end else begin
                     cnt_d = 4'd1;
                  end
               end
            end else if (bus.SP) begin
               if (!bus.STF_EN) begin
                  bit_valid_d = 1'b1;
                  bit_out_d   = bus.RX;
               end else if (run_q >= STUFF_CNT) begin
                  if (bus.RX == last_q) begin
                     state_d     = S_ERR_FLAG;
                     cnt_d       = '0;
                     stuff_err_d = 1'b1;
                     fr_reset_d  = 1'b1;
                  end else begin
                     last_d = bus.RX;
                     run_d  = 4'd1;
                  end
               end else begin
                  bit_valid_d = 1'b1;
                  bit_out_d   = bus.RX;
                  if (bus.RX == last_q) begin
                     run_d = run_q + 4'd1;
                  end else begin
                     run_d  = 4'd1;
                     last_d = bus.RX;
                  end
               end
            end
         end
         S_INTERM: begin
            if (bus.SP) begin
               if (!bus.RX) begin
                  state_d    = S_ERR_FLAG;
                  cnt_d      = '0;
                  fr_reset_d = 1'b1;
               end else if (cnt_inc >= INTERM_CNT) begin
                  state_d    = S_IDLE;
                  cnt_d      = '0;
                  fr_reset_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_ERR_FLAG: begin
            if (bus.SP) begin
               if (cnt_inc >= FLAG_CNT) begin
                  state_d = S_ERR_DELIM;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_ERR_DELIM: begin
            if (bus.SP) begin
               if (!bus.RX) begin
                  cnt_d = '0;
               end else if (cnt_inc >= DELIM_CNT) begin
                  state_d = S_INTERM;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = S_INTEG;
            cnt_d   = '0;
         end
      endcase

      bus_idle_d   = (state_d == S_IDLE);
      err_active_d = (state_d == S_ERR_FLAG) || (state_d == S_ERR_DELIM);
   end

   assign bus.BIT_VALID  = bit_valid_q;
   assign bus.BIT_OUT    = bit_out_q;
   assign bus.FR_RESET   = fr_reset_q;
   assign bus.STUFF_ERR  = stuff_err_q;
   assign bus.BUS_IDLE   = bus_idle_q;
   assign bus.ERR_ACTIVE = err_active_q;
   assign bus.STATE      = state_q;
endmodule
